// File: rtl/fpga_uart_rx_pkg.sv
// Shared types and helpers for the FPGA-harness UART receiver.
// FPGA_UART_RX_PARITY_EN adds the PARITY state (8E1 framing).
package fpga_uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef FPGA_UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } rx_state_e;

    function automatic int clks_per_bit(input int clk_freq_hz, input int baud_rate);
        return clk_freq_hz / baud_rate;
    endfunction

endpackage

// File: rtl/fpga_uart_rx_fifo.sv
// First-word-fall-through FIFO: the head entry is always visible on data.
// A pop frees a slot in the same cycle, so a push into a full FIFO is accepted alongside a pop.
module fpga_uart_rx_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign data    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fpga_uart_rx.sv
// UART receiver for the board wrapper: synchronizer, deframing FSM, sticky error flags and an RX FIFO.
// Define FPGA_UART_RX_PARITY_EN for 8E1 framing; default is 8N1.
module fpga_uart_rx
    import fpga_uart_rx_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 15_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        rx_i,
    output logic [7:0]                  data_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic                        frame_err_o,
    output logic                        overrun_o,
    input  logic                        clear_i,
    output logic [$clog2(FIFO_DEPTH):0] count_o
);

    localparam int CPB   = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int CNT_W = $clog2(CPB);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CPB / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CPB - 1);

    logic             rx_meta;
    logic             rx_s;
    rx_state_e        state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             par_bad;
    logic             bit_tick;
    logic             stop_done;
    logic             push_req;
    logic             frame_bad;
    logic             pop;
    logic             full;
    logic             empty;
    logic             drop;

    // Stage boundary: asynchronous line into the clock domain
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    assign bit_tick  = (baud_cnt == BIT_LAST);
    assign stop_done = (state == ST_STOP) && bit_tick;
    assign push_req  = stop_done && rx_s && !par_bad;
    assign frame_bad = stop_done && (!rx_s || par_bad);

    // Stage boundary: deframing FSM, all sample points on the synchronized line
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
`ifdef FPGA_UART_RX_PARITY_EN
            par_bad  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
`ifdef FPGA_UART_RX_PARITY_EN
                    par_bad  <= 1'b0;
`endif
                    if (!rx_s) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        state    <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        baud_cnt <= '0;
                        bit_idx  <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
`ifdef FPGA_UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef FPGA_UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (bit_tick) begin
                        baud_cnt <= '0;
                        par_bad  <= rx_s ^ (^shift);
                        state    <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    // No wait for a high line: a low stop bit simply re-arms from IDLE.
                    if (bit_tick) begin
                        baud_cnt <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifndef FPGA_UART_RX_PARITY_EN
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (state == ST_DATA && bit_tick) begin
            shift <= {rx_s, shift[7:1]};
        end
    end

    assign pop  = valid_o && ready_i;
    assign drop = push_req && full && !pop;

    // Stage boundary: sticky status, a set event beats a clear in the same cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            if (frame_bad) begin
                frame_err_o <= 1'b1;
            end else if (clear_i) begin
                frame_err_o <= 1'b0;
            end
            if (drop) begin
                overrun_o <= 1'b1;
            end else if (clear_i) begin
                overrun_o <= 1'b0;
            end
        end
    end

    fpga_uart_rx_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (8)
    ) u_fifo (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .push      (push_req),
        .push_data (shift),
        .pop       (pop),
        .data      (data_o),
        .full      (full),
        .empty     (empty),
        .count     (count_o)
    );

    assign valid_o = !empty;

endmodule

// File: tb/tb_fpga_uart_rx.sv
// Directed bench for fpga_uart_rx at 10 clocks per bit with a 4-entry FIFO.
// Frame length and latency follow FPGA_UART_RX_PARITY_EN when it is defined.
module tb_fpga_uart_rx;

    localparam int CPB = 10;
`ifdef FPGA_UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk     = 1'b0;
    logic       rst_ni  = 1'b0;
    logic       rx_i    = 1'b1;
    logic       ready_i = 1'b0;
    logic       clear_i = 1'b0;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic [2:0] count_o;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   t_start  = 0;
    int   rise_cyc = 0;
    logic valid_q  = 1'b0;

    fpga_uart_rx #(
        .CLK_FREQ_HZ (1_000_000),
        .BAUD_RATE   (100_000),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .clear_i     (clear_i),
        .count_o     (count_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_o && !valid_q) rise_cyc <= cyc;
        valid_q <= valid_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Drives one frame from a negedge; pop_at >= 0 raises ready_i for that single cycle of the frame.
    task automatic send(input logic [7:0] d, input logic stop, input logic par_flip, input int pop_at);
        logic [10:0] frame;
        logic        pbit;
        pbit  = (^d) ^ par_flip;
        frame = (NBITS == 11) ? {stop, pbit, d, 1'b0} : {1'b1, stop, d, 1'b0};
        t_start = cyc;
        for (int c = 0; c < NBITS * CPB; c++) begin
            rx_i = frame[c / CPB];
            if (pop_at >= 0) ready_i = (c == pop_at);
            @(negedge clk);
        end
        rx_i = 1'b1;
        if (pop_at >= 0) ready_i = 1'b0;
    endtask

    task automatic pop_one();
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
    endtask

    initial begin
        logic [9:0] pf;
        repeat (3) @(negedge clk);
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_count", count_o, 0);
        check("rst_ferr", frame_err_o, 0);
        check("rst_ovr", overrun_o, 0);
        rst_ni = 1'b1;
        repeat (5) @(negedge clk);

        // Single character: 2 sync cycles plus 96 (plus one bit time with parity)
        send(8'hA5, 1'b1, 1'b0, -1);
        repeat (4) @(negedge clk);
        check("a5_latency", rise_cyc - t_start, 2 + 96 + (NBITS - 10) * CPB);
        check("a5_valid", valid_o, 1);
        check("a5_data", data_o, 8'hA5);
        check("a5_count", count_o, 1);
        pop_one();
        check("a5_popped", valid_o, 0);
        check("a5_cnt0", count_o, 0);

        // Short glitch is a false start
        rx_i = 1'b0;
        repeat (3) @(negedge clk);
        rx_i = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_valid", valid_o, 0);
        check("glitch_count", count_o, 0);
        check("glitch_ferr", frame_err_o, 0);
        check("glitch_ovr", overrun_o, 0);

        // Bad stop bit, clear, then a clean repeat
        send(8'h3C, 1'b0, 1'b0, -1);
        repeat (20) @(negedge clk);
        check("badstop_ferr", frame_err_o, 1);
        check("badstop_valid", valid_o, 0);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        check("clear_ferr", frame_err_o, 0);
        send(8'h3C, 1'b1, 1'b0, -1);
        repeat (4) @(negedge clk);
        check("3c_valid", valid_o, 1);
        check("3c_data", data_o, 8'h3C);
        check("3c_ferr", frame_err_o, 0);
        pop_one();

        // Overrun: five back-to-back characters into four slots
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, 1'b0, -1);
        repeat (4) @(negedge clk);
        check("ovr_count", count_o, 4);
        check("ovr_flag", overrun_o, 1);
        for (int i = 1; i <= 4; i++) begin
            check("ovr_drain", data_o, i);
            pop_one();
        end
        check("ovr_empty", valid_o, 0);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        check("ovr_clear", overrun_o, 0);

        // Full FIFO with a pop on the exact push edge of the fifth character
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b1, 1'b0, -1);
        send(8'h05, 1'b1, 1'b0, NBITS * CPB - 3);
        repeat (4) @(negedge clk);
        check("fullpop_count", count_o, 4);
        check("fullpop_ovr", overrun_o, 0);
        for (int i = 2; i <= 5; i++) begin
            check("fullpop_drain", data_o, i);
            pop_one();
        end
        check("fullpop_empty", count_o, 0);

        // Reset at bit 4 of a frame, with a character already buffered
        send(8'h11, 1'b1, 1'b0, -1);
        repeat (4) @(negedge clk);
        check("pre_rst_count", count_o, 1);
        pf = {1'b1, 8'h99, 1'b0};
        for (int c = 0; c < 5 * CPB; c++) begin
            rx_i = pf[c / CPB];
            @(negedge clk);
        end
        rst_ni = 1'b0;
        rx_i   = 1'b1;
        @(negedge clk);
        check("midrst_count", count_o, 0);
        check("midrst_valid", valid_o, 0);
        check("midrst_data", data_o, 0);
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        repeat (10 * CPB) @(negedge clk);
        check("postrst_count", count_o, 0);
        check("postrst_ferr", frame_err_o, 0);
        send(8'h7E, 1'b1, 1'b0, -1);
        repeat (4) @(negedge clk);
        check("7e_count", count_o, 1);
        check("7e_data", data_o, 8'h7E);
        pop_one();
        check("7e_empty", valid_o, 0);

`ifdef FPGA_UART_RX_PARITY_EN
        // 0x07 has odd weight, so even parity needs a 1; send 0
        send(8'h07, 1'b1, 1'b1, -1);
        repeat (4) @(negedge clk);
        check("par_ferr", frame_err_o, 1);
        check("par_valid", valid_o, 0);
        send(8'h07, 1'b1, 1'b0, -1);
        repeat (4) @(negedge clk);
        check("par_ok_data", data_o, 8'h07);
        check("par_ok_count", count_o, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
